systolic_feeder: RTL and testbench

- Upstream feeder/controller for the 4x4 systolic array multiplier.
- Accepts two 4x4 8-bit matrices A and B through a valid/ready handshake. Builds the diagonally skewed row and column streams that the array consumes.
- Shifts those streams one element per cycle, pulses the array's accumulator clear, then captures the 4x4 16-bit product C = A x B and presents it with its own valid/ready handshake.

---
 rtl/systolic_feeder_if.sv | 35 +++
 rtl/systolic_feeder.sv | 149 ++++++++++++++
 tb/tb_systolic_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_feeder_if
// Groups the job-input handshake, the skewed streams to the systolic array, the
// array accumulator return path and the result handshake of systolic_feeder.
//   i_valid/o_ready   : job handshake, i_a/i_b are the 4x4 8-bit operands
//   o_row/o_col       : skewed A/B streams, element [x][0] is the PE input
//   o_arrayClr        : registered accumulator clear for the array PEs
//   i_c               : array accumulator outputs
//   o_c/o_valid/i_ready : captured product and its handshake
// slave  : view of the feeder itself
// master : view of the surrounding environment (job source, array, sink)
// -----------------------------------------------------------------------------
interface systolic_feeder_if;
  logic                    i_valid;
  logic                    o_ready;
  logic [3:0][3:0][7:0]    i_a;
  logic [3:0][3:0][7:0]    i_b;
  logic [3:0][6:0][7:0]    o_row;
  logic [3:0][6:0][7:0]    o_col;
  logic                    o_arrayClr;
  logic [3:0][3:0][15:0]   i_c;
  logic [3:0][3:0][15:0]   o_c;
  logic                    o_valid;
  logic                    i_ready;

  modport slave (
    input  i_valid, i_a, i_b, i_c, i_ready,
    output o_ready, o_row, o_col, o_arrayClr, o_c, o_valid
  );

  modport master (
    output i_valid, i_a, i_b, i_c, i_ready,
    input  o_ready, o_row, o_col, o_arrayClr, o_c, o_valid
  );
endinterface

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
// Upstream controller for a 4x4 systolic array multiplier. Accepts A and B,
// builds diagonally skewed row/column streams, clears the array accumulators
// for one cycle, shifts the streams one element per cycle, then captures the
// 16-bit product C = A x B from the array and holds it until downstream takes it.
// Ports:
//   i_clk  : clock
//   i_arst : asynchronous active-high reset
//   bus    : systolic_feeder_if.slave (job, stream, array and result signals)
// Timing: acceptance edge -> CLEAR (1 cycle) -> RUN (SHIFT+DRAIN cycles)
//         -> DONE (o_valid held until i_ready) -> IDLE.
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int unsigned SHIFT_CYCLES = 7,
  parameter int unsigned DRAIN_CYCLES = 7
) (
  input  logic              i_clk,
  input  logic              i_arst,
  systolic_feeder_if.slave  bus
);

  localparam int unsigned RUN_CYCLES = SHIFT_CYCLES + DRAIN_CYCLES;
  localparam int unsigned CNT_W      = $clog2(RUN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SHIFT = CNT_W'(SHIFT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  typedef logic [3:0][6:0][7:0]  stream_t;
  typedef logic [3:0][3:0][15:0] cmat_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  stream_t           row_q, row_d;
  stream_t           col_q, col_d;
  cmat_t             c_q, c_d;
  logic              clr_q, clr_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  // NOTE: every registered value here is a plain flop (no RAM), so the whole
  // state including the streams and the captured product is cleared by reset.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      c_q     <= '0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      c_q     <= c_d;
      clr_q   <= clr_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    c_d     = c_q;
    clr_d   = 1'b0;
    valid_d = valid_q;
    ready_d = ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid && ready_q) begin
          // Row i is delayed by i slots and column j by j slots so that
          // A[i][k] and B[k][j] meet at PE(i,j) in the same cycle.
          row_d = '0;
          col_d = '0;
          for (int x = 0; x < 4; x++) begin
            for (int e = 0; e < 4; e++) begin
              row_d[x][x+e] = bus.i_a[x][e];
              col_d[x][x+e] = bus.i_b[e][x];
            end
          end
          clr_d   = 1'b1;
          ready_d = 1'b0;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        if (cnt_q < CNT_SHIFT) begin
          for (int x = 0; x < 4; x++) begin
            for (int k = 0; k < 6; k++) begin
              row_d[x][k] = row_q[x][k+1];
              col_d[x][k] = col_q[x][k+1];
            end
            row_d[x][6] = '0;
            col_d[x][6] = '0;
          end
        end
        if (cnt_q == CNT_LAST) begin
          // The drain period guarantees the last MAC has landed in i_c.
          c_d     = bus.i_c;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_arrayClr = clr_q;
  assign bus.o_row      = row_q;
  assign bus.o_col      = col_q;
  assign bus.o_c        = c_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
// Drives jobs into systolic_feeder, emulates the 4x4 systolic array it feeds,
// and compares every cycle against a job-phase model that derives expected
// handshakes, streams and products from matrix arithmetic.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

  typedef logic [3:0][3:0][7:0]  mat8_t;
  typedef logic [3:0][3:0][15:0] mat16_t;
  typedef logic [3:0][6:0][7:0]  stream_t;

  logic i_clk = 1'b0;
  logic i_arst;

  always #5 i_clk = ~i_clk;

  systolic_feeder_if bus ();

  systolic_feeder #(
    .SHIFT_CYCLES (7),
    .DRAIN_CYCLES (7)
  ) dut (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- systolic array emulation ----------------
  logic [7:0]  pa  [4][4];
  logic [7:0]  pb  [4][4];
  logic [15:0] acc [4][4];

  function automatic logic [7:0] a_in(int i, int j);
    if (j == 0) return bus.o_row[i][0];
    return pa[i][j-1];
  endfunction

  function automatic logic [7:0] b_in(int i, int j);
    if (i == 0) return bus.o_col[j][0];
    return pb[i-1][j];
  endfunction

  always @(posedge i_clk or posedge i_arst) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i_arst || bus.o_arrayClr) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= a_in(i, j);
          pb[i][j]  <= b_in(i, j);
          acc[i][j] <= acc[i][j] + a_in(i, j) * b_in(i, j);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        bus.i_c[i][j] = acc[i][j];
  end

  // ---------------- reference model ----------------
  function automatic mat16_t matmul(mat8_t a, mat8_t b);
    mat16_t c;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [15:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s = s + a[i][k] * b[k][j];
        c[i][j] = s;
      end
    end
    return c;
  endfunction

  // Stream contents after sh shifts: slot k holds original element k+sh.
  function automatic stream_t exp_rows(mat8_t a, int sh);
    stream_t r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 7; k++) begin
        int idx;
        int e;
        idx = k + sh;
        e   = idx - i;
        if (idx <= 6 && e >= 0 && e <= 3) r[i][k] = a[i][e];
      end
    return r;
  endfunction

  function automatic stream_t exp_cols(mat8_t b, int sh);
    stream_t r;
    r = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 7; k++) begin
        int idx;
        int e;
        idx = k + sh;
        e   = idx - j;
        if (idx <= 6 && e >= 0 && e <= 3) r[j][k] = b[e][j];
      end
    return r;
  endfunction

  // Job phase: 0 idle, 1 clear cycle, 2..15 run cycles 0..13, 16 result held.
  int     ph     = 0;
  mat8_t  m_a    = '0;
  mat8_t  m_b    = '0;
  mat16_t m_hold = '0;

  function automatic int shifts(int p);
    if (p == 1) return 0;
    if (p >= 2 && p <= 15) return (p - 2 < 7) ? p - 2 : 7;
    return 7;
  endfunction

  always @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      ph     <= 0;
      m_a    <= '0;
      m_b    <= '0;
      m_hold <= '0;
    end else if (ph == 0) begin
      if (bus.i_valid) begin
        m_a <= bus.i_a;
        m_b <= bus.i_b;
        ph  <= 1;
      end
    end else if (ph < 16) begin
      if (ph == 15) m_hold <= matmul(m_a, m_b);
      ph <= ph + 1;
    end else if (bus.i_ready) begin
      ph <= 0;
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("ready",    bus.o_ready,      ph == 0);
      check("valid",    bus.o_valid,      ph == 16);
      check("arrayclr", bus.o_arrayClr,   ph == 1);
      check("rows",     bus.o_row,        exp_rows(m_a, shifts(ph)));
      check("cols",     bus.o_col,        exp_cols(m_b, shifts(ph)));
      check("c",        bus.o_c,          m_hold);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic mat8_t garbage();
    mat8_t g;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) g[i][j] = 8'($urandom);
    return g;
  endfunction

  // Returns at the falling edge of the CLEAR cycle (cycle 1 after acceptance).
  task automatic send(input mat8_t a, input mat8_t b);
    int n;
    @(negedge i_clk);
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_valid = 1'b1;
    n = 0;
    while (!bus.o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("ready_wait_timeout", n >= 100, 1'b0);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    bus.i_a     = garbage();
    bus.i_b     = garbage();
  endtask

  task automatic wait_valid(output int lat, output int clr_hi);
    lat    = 1;
    clr_hi = bus.o_arrayClr ? 1 : 0;
    while (!bus.o_valid && lat < 40) begin
      @(negedge i_clk);
      lat++;
      if (bus.o_arrayClr) clr_hi++;
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    mat8_t  a, b;
    mat16_t e;
    int     lat, clr_hi;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    mat8_t  a, b;
    mat16_t e;
    int     lat, clr_hi;

    i_arst      = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_a     = '0;
    bus.i_b     = '0;
    repeat (2) @(negedge i_clk);
    chk_en = 1'b1;
    check("rst_ready", bus.o_ready, 1'b1);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_clr",   bus.o_arrayClr, 1'b0);
    check("rst_c",     bus.o_c, '0);
    check("rst_rows",  bus.o_row, '0);
    i_arst = 1'b0;

    // Identity A, B[r][c] = 4r+c+1.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = (r == c) ? 8'd1 : 8'd0;
        b[r][c] = 8'(4 * r + c + 1);
      end
    send(a, b);
    wait_valid(lat, clr_hi);
    check("t1_latency", lat, 16);
    check("t1_clr_width", clr_hi, 1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) e[r][c] = 16'(4 * r + c + 1);
    check("t1_c", bus.o_c, e);
    @(negedge i_clk);

    // A[r][c] = r+c, B all 2; also pin the skew layout.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = 8'(r + c);
        b[r][c] = 8'd2;
      end
    send(a, b);
    check("t2_row22", bus.o_row[2][2], 8'd2);
    check("t2_row21", bus.o_row[2][1], 8'd0);
    check("t2_col36", bus.o_col[3][6], 8'd2);
    check("t2_row30", bus.o_row[3][0], 8'd0);
    repeat (8) @(negedge i_clk);
    check("t2_rows_drained", bus.o_row, '0);
    check("t2_cols_drained", bus.o_col, '0);
    wait_valid(lat, clr_hi);
    check("t2_c00", bus.o_c[0][0], 16'd12);
    check("t2_c33", bus.o_c[3][3], 16'd36);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) e[r][c] = 16'(2 * (4 * r + 6));
    check("t2_c", bus.o_c, e);
    @(negedge i_clk);

    // All 255: 4*255*255 = 260100 wraps to 0xF804.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = 8'hFF;
        b[r][c] = 8'hFF;
        e[r][c] = 16'hF804;
      end
    send(a, b);
    wait_valid(lat, clr_hi);
    check("t3_c", bus.o_c, e);
    @(negedge i_clk);

    // Back-to-back with a 5-cycle stall on the first result.
    bus.i_ready = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = 8'(r + 1);
        b[r][c] = 8'(c + 1);
        e[r][c] = 16'(4 * (r + 1) * (c + 1));
      end
    send(a, b);
    wait_valid(lat, clr_hi);
    check("t4_latency", lat, 16);
    check("t4_c12", bus.o_c[1][2], 16'd24);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = 8'd1;
        b[r][c] = 8'(r);
      end
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_valid = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      check("t4_stall_c",     bus.o_c, e);
      check("t4_stall_valid", bus.o_valid, 1'b1);
      check("t4_stall_ready", bus.o_ready, 1'b0);
    end
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    check("t4_hs_valid", bus.o_valid, 1'b0);
    check("t4_hs_ready", bus.o_ready, 1'b1);
    @(negedge i_clk);
    check("t4_accept_clr", bus.o_arrayClr, 1'b1);
    bus.i_valid = 1'b0;
    bus.i_a     = garbage();
    bus.i_b     = garbage();
    wait_valid(lat, clr_hi);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) e[r][c] = 16'd6;
    check("t4_job2_c", bus.o_c, e);
    @(negedge i_clk);

    // Reset during RUN cycle 5, then a fresh job.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = 8'(3 * r + c + 5);
        b[r][c] = 8'(r * c + 1);
      end
    send(a, b);
    repeat (6) @(negedge i_clk);
    #2 i_arst = 1'b1;
    #1;
    check("t5_rst_valid", bus.o_valid, 1'b0);
    check("t5_rst_ready", bus.o_ready, 1'b1);
    check("t5_rst_clr",   bus.o_arrayClr, 1'b0);
    check("t5_rst_rows",  bus.o_row, '0);
    check("t5_rst_cols",  bus.o_col, '0);
    check("t5_rst_c",     bus.o_c, '0);
    @(negedge i_clk);
    i_arst = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = (r == c) ? 8'd1 : 8'd0;
        b[r][c] = 8'd7;
        e[r][c] = 16'd7;
      end
    send(a, b);
    wait_valid(lat, clr_hi);
    check("t5_latency", lat, 16);
    check("t5_c", bus.o_c, e);
    @(negedge i_clk);
    @(negedge i_clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
